// File: rtl/button_input_arbiter.sv
// Button input arbiter for the Simon game.
// Accepts one debounced button per window, reports press events and timeouts.
module button_input_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 150000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] clean_btn,
  output logic [3:0] btn_held,
  output logic       press_valid,
  output logic [1:0] press_idx,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_PRESS,
    HELD,
    REJECT,
    EXPIRED
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       btn_held_q, btn_held_d;
  logic [1:0]       press_idx_q, press_idx_d;
  logic             press_valid_q, press_valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  logic       btn_any;
  logic       btn_multi;
  logic       btn_one;
  logic [1:0] btn_idx;
  logic       expire;
  logic       held_rel;

  // Classify the button vector: none, exactly one, or several pressed.
  always_comb begin
    btn_any   = |clean_btn;
    btn_multi = (clean_btn & (clean_btn - 4'd1)) != 4'd0;
    btn_one   = btn_any & ~btn_multi;
    btn_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (clean_btn[i]) btn_idx = 2'(i);
    end
    expire    = TO_EN && (cnt_q == LIMIT);
    held_rel  = (clean_btn & btn_held_q) == 4'd0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    btn_held_d    = btn_held_q;
    press_idx_d   = press_idx_q;
    press_valid_d = 1'b0;
    timeout_d     = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      btn_held_d = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (!btn_any) begin
            state_d = WAIT_PRESS;
            cnt_d   = '0;
          end
        end
        WAIT_PRESS: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (btn_one) begin
            state_d     = HELD;
            btn_held_d  = clean_btn;
            press_idx_d = btn_idx;
          end else if (btn_multi) begin
            state_d = REJECT;
          end else if (expire) begin
            state_d   = EXPIRED;
            timeout_d = 1'b1;
          end
        end
        HELD: begin
          if (held_rel) begin
            press_valid_d = 1'b1;
            btn_held_d    = 4'd0;
            if (btn_any) begin
              state_d = ARM;
            end else begin
              state_d = WAIT_PRESS;
              cnt_d   = '0;
            end
          end
        end
        REJECT: begin
          cnt_d = cnt_q + CNT_W'(1);
          // Expiry wins so a release on the limit cycle cannot skip it.
          if (expire) begin
            state_d   = EXPIRED;
            timeout_d = 1'b1;
          end else if (!btn_any) begin
            state_d = WAIT_PRESS;
          end
        end
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == HELD) || (state_d == REJECT);
  end

  // State, counter and output registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      btn_held_q    <= 4'd0;
      press_idx_q   <= 2'd0;
      press_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_held_q    <= btn_held_d;
      press_idx_q   <= press_idx_d;
      press_valid_q <= press_valid_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign btn_held    = btn_held_q;
  assign press_valid = press_valid_q;
  assign press_idx   = press_idx_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_button_input_arbiter.sv
// Scoreboard bench for button_input_arbiter.
// Expected press/timeout events are queued; a monitor pops on each pulse.
module tb_button_input_arbiter;

  logic       sysclk;
  logic       reset;
  logic       enable;
  logic [3:0] clean_btn;
  logic [3:0] btn_held;
  logic       press_valid;
  logic [1:0] press_idx;
  logic       timeout;
  logic       busy;

  button_input_arbiter #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(32)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .enable(enable),
    .clean_btn(clean_btn),
    .btn_held(btn_held),
    .press_valid(press_valid),
    .press_idx(press_idx),
    .timeout(timeout),
    .busy(busy)
  );

  typedef struct {
    bit         to;
    logic [1:0] idx;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] got,
                      input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic got,
                      input logic exp);
    chk4(nm, {3'b000, got}, {3'b000, exp});
  endtask

  task automatic expect_ev(input bit to, input logic [1:0] idx,
                           input int c);
    ev_t e;
    e.to  = to;
    e.idx = idx;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge sysclk);
      if (!reset && (press_valid || timeout)) begin
        checks++;
        if (press_valid && timeout) begin
          errors++;
          $display("FAIL both_pulses: got pv=1 to=1, required one (cycle %0d)",
                   cyc);
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got pv=%0b to=%0b idx=%0d cycle %0d, required none",
                   press_valid, timeout, press_idx, cyc);
        end else begin
          e = sb.pop_front();
          if (e.to != timeout || (!e.to && e.idx != press_idx)
              || e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got to=%0b idx=%0d cycle %0d, required to=%0b idx=%0d cycle %0d",
                     timeout, press_idx, cyc, e.to, e.idx, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic idle_gap();
    enable    = 1'b0;
    clean_btn = 4'd0;
    tick(2);
  endtask

  task automatic open_window();
    enable = 1'b1;
    tick(2);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset with a button down: everything clear.
    reset     = 1'b1;
    enable    = 1'b0;
    clean_btn = 4'b0010;
    #3;
    chk4("rst_btn_held", btn_held, 4'd0);
    chk1("rst_press_valid", press_valid, 1'b0);
    chk4("rst_press_idx", {2'b00, press_idx}, 4'd0);
    chk1("rst_timeout", timeout, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(10);
    chk4("idle_btn_held", btn_held, 4'd0);
    chk1("idle_busy", busy, 1'b0);

    // Single press of button 2.
    clean_btn = 4'd0;
    open_window();
    clean_btn = 4'b0100;
    tick(1);
    chk4("single_held", btn_held, 4'b0100);
    chk1("single_busy", busy, 1'b1);
    tick(19);
    clean_btn = 4'd0;
    expect_ev(1'b0, 2'd2, cyc + 1);
    tick(1);
    chk4("single_rel_held", btn_held, 4'd0);
    tick(1);
    chk4("single_idx_hold", {2'b00, press_idx}, 4'd2);
    idle_gap();

    // Two buttons at once are rejected.
    open_window();
    clean_btn = 4'b0011;
    tick(1);
    chk1("rej_busy", busy, 1'b1);
    chk4("rej_held", btn_held, 4'd0);
    tick(9);
    chk1("rej_busy_late", busy, 1'b1);
    clean_btn = 4'd0;
    tick(1);
    chk1("rej_busy_end", busy, 1'b0);
    idle_gap();

    // Button carried into the window, then a late second button.
    clean_btn = 4'b1000;
    enable    = 1'b1;
    tick(4);
    chk4("carry_held", btn_held, 4'd0);
    chk1("carry_busy", busy, 1'b0);
    clean_btn = 4'd0;
    tick(1);
    clean_btn = 4'b0001;
    tick(1);
    chk4("late_held0", btn_held, 4'b0001);
    clean_btn = 4'b0011;
    tick(2);
    chk4("late_held_keep", btn_held, 4'b0001);
    clean_btn = 4'b0010;
    expect_ev(1'b0, 2'd0, cyc + 1);
    tick(1);
    chk4("late_arm_held", btn_held, 4'd0);
    chk1("late_arm_busy", busy, 1'b0);
    tick(3);
    chk4("late_arm_stay", btn_held, 4'd0);
    clean_btn = 4'd0;
    tick(1);
    clean_btn = 4'b1000;
    tick(1);
    chk4("after_arm_held", btn_held, 4'b1000);
    clean_btn = 4'd0;
    expect_ev(1'b0, 2'd3, cyc + 1);
    tick(1);
    idle_gap();

    // Timeout 16 cycles after entering WAIT_PRESS, once per window.
    open_window();
    expect_ev(1'b1, 2'd0, cyc + 16);
    tick(30);
    chk1("exp_busy", busy, 1'b0);
    idle_gap();
    open_window();
    expect_ev(1'b1, 2'd0, cyc + 16);
    tick(20);
    idle_gap();

    // Press on the 16th cycle beats the timeout; enable drop kills it.
    open_window();
    tick(15);
    clean_btn = 4'b0010;
    tick(1);
    chk4("bound_held", btn_held, 4'b0010);
    tick(3);
    enable    = 1'b0;
    clean_btn = 4'd0;
    tick(1);
    chk4("drop_held", btn_held, 4'd0);
    chk1("drop_busy", busy, 1'b0);
    tick(3);

    // Reset while a button is held, button still down afterwards.
    clean_btn = 4'd0;
    open_window();
    clean_btn = 4'b0100;
    tick(1);
    #2;
    reset = 1'b1;
    #1;
    chk4("rst_mid_held", btn_held, 4'd0);
    chk1("rst_mid_busy", busy, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(4);
    chk4("rst_arm_held", btn_held, 4'd0);
    chk1("rst_arm_busy", busy, 1'b0);
    clean_btn = 4'd0;
    tick(3);
    idle_gap();
    tick(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending, required 0",
               sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
